// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing.
// ROB_TAG_W is also the CDB tag width used by the arbiter and functional units.
package rob_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_SZ    = 8;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_SZ);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  // Index plus wrap bit, so full and empty can be told apart
  typedef logic [ROB_TAG_W:0]   rob_ptr_t;

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Reorder-buffer bus: dispatch, CDB capture and retire signal groups.
// Optional feature macro: ROB_SQUASH_EN adds the squash input.
interface rob_if;
  import rob_pkg::*;

  logic                 dispatch_valid;
  logic [4:0]           dispatch_dest_reg;
  rob_tag_t             dispatch_tag;
  logic                 rob_full;
  logic                 rob_empty;
  logic [ROB_TAG_W:0]   rob_count;
  logic                 cdb_valid;
  rob_tag_t             cdb_tag;
  logic [XLEN-1:0]      cdb_value;
  logic                 retire_valid;
  rob_tag_t             retire_tag;
  logic [4:0]           retire_dest_reg;
  logic [XLEN-1:0]      retire_value;
`ifdef ROB_SQUASH_EN
  logic                 squash;
`endif

  // Core side: dispatch stage, CDB arbiter and commit
  modport master (
`ifdef ROB_SQUASH_EN
    output squash,
`endif
    output dispatch_valid, dispatch_dest_reg, cdb_valid, cdb_tag, cdb_value,
    input  dispatch_tag, rob_full, rob_empty, rob_count,
    input  retire_valid, retire_tag, retire_dest_reg, retire_value
  );

  // Reorder buffer side
  modport slave (
`ifdef ROB_SQUASH_EN
    input  squash,
`endif
    input  dispatch_valid, dispatch_dest_reg, cdb_valid, cdb_tag, cdb_value,
    output dispatch_tag, rob_full, rob_empty, rob_count,
    output retire_valid, retire_tag, retire_dest_reg, retire_value
  );

endinterface

// File: rtl/rob.sv
// Eight-entry reorder buffer: in-order allocate, CDB capture, in-order retire.
// Optional feature macro: ROB_SQUASH_EN (squash flushes every entry).
module rob
  import rob_pkg::*;
(
  input logic  clock,
  input logic  reset,
  rob_if.slave bus
);

  rob_entry_t entries [ROB_SZ];
  rob_ptr_t   head;
  rob_ptr_t   tail;

  rob_tag_t   head_idx;
  rob_tag_t   tail_idx;
  rob_entry_t head_entry;
  logic       full;
  logic       empty;
  logic       squash_req;
  logic       retire_fire;
  logic       dispatch_fire;
  logic       cdb_hit;

`ifdef ROB_SQUASH_EN
  assign squash_req = bus.squash;
`else
  assign squash_req = 1'b0;
`endif

  // Status and event decode; status depends on registered pointers only
  always_comb begin
    head_idx      = head[ROB_TAG_W-1:0];
    tail_idx      = tail[ROB_TAG_W-1:0];
    head_entry    = entries[head_idx];
    full          = (head_idx == tail_idx) && (head[ROB_TAG_W] != tail[ROB_TAG_W]);
    empty         = (head == tail);
    // Full is taken before this cycle's retire, so a freed head does not admit dispatch
    dispatch_fire = bus.dispatch_valid && !full;
    cdb_hit       = bus.cdb_valid && entries[bus.cdb_tag].valid;
    retire_fire   = head_entry.valid && head_entry.complete && !squash_req;

    bus.dispatch_tag = tail_idx;
    bus.rob_full     = full;
    bus.rob_empty    = empty;
    bus.rob_count    = tail - head;
  end

  // Retire port; data forced to zero when nothing retires
  always_comb begin
    bus.retire_valid    = retire_fire;
    bus.retire_tag      = '0;
    bus.retire_dest_reg = '0;
    bus.retire_value    = '0;
    if (retire_fire) begin
      bus.retire_tag      = head_idx;
      bus.retire_dest_reg = head_entry.dest_reg;
      bus.retire_value    = head_entry.value;
    end
  end

  // Entry array and pointer update; dispatch, capture and retire touch different entries
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        entries[i] <= '0;
      end
    end else if (squash_req) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        entries[i].valid    <= 1'b0;
        entries[i].complete <= 1'b0;
      end
    end else begin
      if (cdb_hit) begin
        entries[bus.cdb_tag].complete <= 1'b1;
        entries[bus.cdb_tag].value    <= bus.cdb_value;
      end
      // Placed after capture so a retiring head always ends invalid
      if (retire_fire) begin
        entries[head_idx].valid    <= 1'b0;
        entries[head_idx].complete <= 1'b0;
        head                       <= head + 1'b1;
      end
      if (dispatch_fire) begin
        entries[tail_idx] <= '{valid: 1'b1, complete: 1'b0,
                               dest_reg: bus.dispatch_dest_reg, value: '0};
        tail              <= tail + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue-based program-order model predicts status
// and the retire stream; a separate monitor compares each cycle's retire port.
module tb_rob;
  import rob_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rob_if bus ();

  rob dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]      tag;
    logic [4:0]      dest;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;

  // Reference model: in-flight tags in program order plus per-tag state
  int              inflight[$];
  int              next_tag;
  bit              m_valid    [8];
  bit              m_complete [8];
  logic [4:0]      m_dest     [8];
  logic [XLEN-1:0] m_value    [8];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    inflight.delete();
    next_tag = 0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i]    = 1'b0;
      m_complete[i] = 1'b0;
    end
  endfunction

  // One clock of stimulus; model predicts, then advances at the edge
  task automatic cycle(input int dv, input int dr, input int cv, input int ct,
                       input logic [XLEN-1:0] cval, input int sq);
    bit sq_eff;
    bit exp_ret;
    bit was_full;
    int h;
    sq_eff = 1'b0;
`ifdef ROB_SQUASH_EN
    sq_eff = (sq != 0);
`endif
    @(negedge clock);
    bus.dispatch_valid    = (dv != 0);
    bus.dispatch_dest_reg = 5'(dr);
    bus.cdb_valid         = (cv != 0);
    bus.cdb_tag           = 3'(ct);
    bus.cdb_value         = cval;
`ifdef ROB_SQUASH_EN
    bus.squash            = sq_eff;
`endif
    #1;
    exp_ret = 1'b0;
    if (!reset) begin
      chk("rob_count", XLEN'(bus.rob_count), XLEN'(inflight.size()));
      chk("rob_full", XLEN'(bus.rob_full), XLEN'(inflight.size() == 8));
      chk("rob_empty", XLEN'(bus.rob_empty), XLEN'(inflight.size() == 0));
      chk("dispatch_tag", XLEN'(bus.dispatch_tag), XLEN'(next_tag));
      if (!sq_eff && inflight.size() > 0) begin
        h = inflight[0];
        if (m_complete[h]) begin
          exp_ret = 1'b1;
          exp_q.push_back('{tag: 3'(h), dest: m_dest[h], val: m_value[h]});
        end
      end
    end
    @(posedge clock);
    if (reset || sq_eff) begin
      model_clear();
    end else begin
      was_full = (inflight.size() == 8);
      if (cv != 0 && m_valid[ct]) begin
        m_complete[ct] = 1'b1;
        m_value[ct]    = cval;
      end
      if (exp_ret) begin
        h = inflight.pop_front();
        m_valid[h]    = 1'b0;
        m_complete[h] = 1'b0;
      end
      if (dv != 0 && !was_full) begin
        m_valid[next_tag]    = 1'b1;
        m_complete[next_tag] = 1'b0;
        m_dest[next_tag]     = 5'(dr);
        m_value[next_tag]    = '0;
        inflight.push_back(next_tag);
        next_tag = (next_tag + 1) % 8;
      end
    end
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    reset  = 1'b1;
    cycle(0, 0, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, '0, 0);
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    mon_on = 1'b1;
  endtask

  // Monitor: compares the retire port against the scoreboard every cycle
  always @(negedge clock) begin
    exp_t e;
    #2;
    if (mon_on) begin
      if (bus.retire_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("retire_unexpected", XLEN'(bus.retire_tag), XLEN'(8));
        end else begin
          e = exp_q.pop_front();
          chk("retire_tag", XLEN'(bus.retire_tag), XLEN'(e.tag));
          chk("retire_dest", XLEN'(bus.retire_dest_reg), XLEN'(e.dest));
          chk("retire_value", bus.retire_value, e.val);
        end
      end else begin
        chk("retire_missing", XLEN'(bus.retire_valid), XLEN'(exp_q.size() != 0));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk("retire_idle_data", XLEN'(bus.retire_tag) | XLEN'(bus.retire_dest_reg) |
            bus.retire_value, '0);
      end
    end
  end

  initial begin
    int ct;
    bus.dispatch_valid    = 1'b0;
    bus.dispatch_dest_reg = '0;
    bus.cdb_valid         = 1'b0;
    bus.cdb_tag           = '0;
    bus.cdb_value         = '0;
`ifdef ROB_SQUASH_EN
    bus.squash            = 1'b0;
`endif
    model_clear();
    do_reset();
    repeat (2) cycle(0, 0, 0, 0, '0, 0);

    // Fill with dest 1..8, then a 9th that must be dropped
    for (int i = 1; i <= 9; i++) cycle(1, i, 0, 0, '0, 0);

    // Out-of-order completion with dispatch held high on a full buffer
    cycle(1, 20, 1, 2, 32'h22, 0);
    cycle(1, 20, 1, 0, 32'h11, 0);
    cycle(1, 20, 1, 1, 32'h33, 0);
    repeat (3) cycle(1, 21, 0, 0, '0, 0);
    repeat (2) cycle(0, 0, 0, 0, '0, 0);

    // Broadcast to an invalid entry is ignored; entry 5 later starts incomplete
    do_reset();
    cycle(0, 0, 1, 5, 32'h55, 0);
    for (int i = 0; i < 6; i++) cycle(1, i + 1, 0, 0, '0, 0);
    repeat (2) cycle(0, 0, 0, 0, '0, 0);
    cycle(0, 0, 1, 5, 32'h5a, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, i, 32'(32'h100 + i), 0);
    repeat (3) cycle(0, 0, 0, 0, '0, 0);

`ifdef ROB_SQUASH_EN
    // Squash with head complete, dispatch and CDB in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, i + 3, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 32'hab, 0);
    cycle(1, 9, 1, 1, 32'hcd, 1);
    repeat (2) cycle(0, 0, 0, 0, '0, 0);
`endif

    // Randomized traffic, CDB biased toward in-flight tags
    for (int n = 0; n < 600; n++) begin
      if (inflight.size() > 0 && $urandom_range(9, 0) < 8)
        ct = inflight[$urandom_range(inflight.size() - 1, 0)];
      else
        ct = int'($urandom_range(7, 0));
      cycle(int'($urandom_range(9, 0) < 6), int'($urandom_range(31, 0)),
            int'($urandom_range(9, 0) < 5), ct, $urandom(),
            int'($urandom_range(99, 0) < 2));
    end
    for (int n = 0; n < 12; n++) begin
      ct = (inflight.size() > 0) ? inflight[0] : 0;
      cycle(0, 0, 1, ct, $urandom(), 0);
    end
    repeat (2) cycle(0, 0, 0, 0, '0, 0);

    mon_on = 1'b0;
    chk("scoreboard_drained", XLEN'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Eight-entry reorder buffer sitting directly downstream of the common data bus (CDB) arbiter in the out-of-order core. Dispatch allocates one entry per cycle in program order, and the entry index is the tag carried through the functional units. The block captures each CDB broadcast into the matching entry and retires completed entries in order from the head, handing destination register and value to architectural commit.

## Interface
- `ROB_SZ`, 8: number of entries; power of two; tag width is log2(ROB_SZ)
- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `dispatch_valid`  in  1  allocate one entry this cycle
- `dispatch_dest_reg`  in  5  architectural destination register of the dispatched instruction
- `dispatch_tag`  out  3  tag the next dispatch receives (current tail index)
- `rob_full`  out  1  all entries allocated; dispatch is ignored while high
- `rob_empty`  out  1  no entries allocated
- `rob_count`  out  4  number of allocated entries, 0..8
- `cdb_valid`  in  1  CDB broadcast valid (`valid_cdb_out` of the arbiter)
- `cdb_tag`  in  3  tag of the broadcasting instruction
- `cdb_value`  in  `XLEN`  result value
- `retire_valid`  out  1  head entry retires this cycle
- `retire_tag`  out  3  head index
- `retire_dest_reg`  out  5  head destination register
- `retire_value`  out  `XLEN`  head result
- `squash`  in  1  flush all entries; present only with `ROB_SQUASH_EN`

## Operation
- State: entry array of {valid, complete, dest_reg, value}; `head` and `tail` pointers, 3-bit index plus wrap bit.
- Full when index bits are equal and wrap bits differ; empty when both are equal. Count is tail minus head over 4 bits.
- Dispatch: accepted when `dispatch_valid` and not `rob_full`, with full evaluated from registered state before this cycle's retire. On acceptance, entry[tail] gets valid=1, complete=0, dest_reg, value=0, and tail increments with wrap. Dispatch while full is dropped silently and the tail is unchanged.
- CDB capture: when `cdb_valid` and entry[cdb_tag].valid, set complete=1 and store value. A broadcast to an invalid entry is ignored. A broadcast to an already-complete entry overwrites the value.
- Retire: `retire_valid` = entry[head].valid & entry[head].complete, computed combinationally from registered state. When high, entry[head].valid clears and head increments with wrap. At most one retire per cycle.
- When `retire_valid`=0, `retire_tag`, `retire_dest_reg` and `retire_value` drive 0.
- Dispatch, CDB capture and retire can all occur in the same cycle, each on different entries. Freeing the head in a full cycle does not admit that cycle's dispatch.
- Destination register 0 is retired normally; downstream commit discards it.

## Timing
- Reset values: head=tail=0, all entries valid=0/complete=0, `rob_full`=0, `rob_empty`=1, `rob_count`=0, `dispatch_tag`=0, `retire_valid`=0, retire data 0. Reset overrides all inputs in the same edge.
- `dispatch_tag`, `rob_full`, `rob_empty` and `rob_count` are functions of registered state only, with no combinational path from inputs.
- CDB to retire: a broadcast on the head tag in cycle N gives `retire_valid`=1 in cycle N+1.
- Minimum dispatch to retire: dispatch in N, CDB in N+1, retire in N+2.
- A full buffer with head retiring in cycle N accepts dispatch in N+1.

## Configuration
- `ROB_SQUASH_EN` defined: the `squash` port exists. `squash`=1 forces `retire_valid`=0 that cycle. At the next edge it invalidates all entries and sets head=tail=0, taking priority over dispatch, CDB capture and retire in the same cycle.
- Not defined: there is no `squash` port. Entries leave only through retirement.

## Structure
- Shared package holds `ROB_SZ`, `ROB_TAG_W`=3, and `rob_entry_t` {valid, complete, dest_reg[4:0], value[XLEN-1:0]}.
- `ROB_TAG_W` is also the CDB tag width used by the arbiter and the functional units.
- Single module; no sub-module. Pointer arithmetic is inline.

## Test plan
- Reset, then idle -> `rob_empty`=1, `rob_count`=0, `dispatch_tag`=0, `retire_valid`=0.
- Dispatch dest regs 1..8 on consecutive cycles, then a 9th -> tags 0..7 assigned, `rob_full`=1, 9th dropped, `rob_count`=8.
- Broadcast out of order: tag 2 value 0x22, tag 0 value 0x11, then tag 1 value 0x33 -> retire tag0/0x11 one cycle after its broadcast, followed by tag1/0x33 and tag2/0x22 on consecutive cycles.
- Full buffer with head complete, dispatch held high -> retire in N, dispatch accepted in N+1 with `dispatch_tag`=0 (wrap), `rob_count` returns to 8.
- Broadcast to tag 5 while entry 5 is invalid -> no state change; a later dispatch into entry 5 shows complete=0.
- With `ROB_SQUASH_EN`: 5 entries valid, `squash` together with dispatch and CDB -> next cycle `rob_empty`=1, head=tail=0, and nothing retired in the squash cycle.
